pipe_hazard_ctrl: RTL and testbench

- Central sequencer for the 5-stage pipelined CPU. Drives load-enable and flush (bubble-insert) strobes for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the EX-stage forwarding mux selects.
- Resolves four hazard classes: load-use, taken branch, multi-cycle multiply/divide occupancy in EX, and data-memory wait.
- Holds an FSM and an occupancy counter. Sits beside the datapath and feeds every pipeline register's en/flush pins.

---
 rtl/pipe_hazard_ctrl_if.sv | 51 +++++
 rtl/pipe_hazard_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard/sequencing bundle between the CPU datapath and pipe_hazard_ctrl
interface pipe_hazard_ctrl_if;
    // Hazard sources observed in the pipeline
    logic [4:0] ID_rs;
    logic [4:0] ID_rt;
    logic       ID_uses_rs;
    logic       ID_uses_rt;
    logic [4:0] ID_EX_rs;
    logic [4:0] ID_EX_rt;
    logic       ID_EX_MemRead;
    logic [4:0] ID_EX_WN;
    logic       ID_EX_md;
    logic       ex_branch_taken;
    logic       EX_MEM_RegWrite;
    logic [4:0] EX_MEM_WN;
    logic       MEM_WB_RegWrite;
    logic [4:0] MEM_WB_WN;
    logic       dmem_wait;

    // Pipeline register strobes and forwarding selects
    logic       pc_en;
    logic       if_id_en;
    logic       if_id_flush;
    logic       id_ex_en;
    logic       id_ex_flush;
    logic       ex_mem_en;
    logic       ex_mem_flush;
    logic       mem_wb_en;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    modport master (
        output ID_rs, ID_rt, ID_uses_rs, ID_uses_rt,
        output ID_EX_rs, ID_EX_rt, ID_EX_MemRead, ID_EX_WN, ID_EX_md,
        output ex_branch_taken,
        output EX_MEM_RegWrite, EX_MEM_WN, MEM_WB_RegWrite, MEM_WB_WN,
        output dmem_wait,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
        input  ex_mem_en, ex_mem_flush, mem_wb_en, fwd_a, fwd_b
    );

    modport slave (
        input  ID_rs, ID_rt, ID_uses_rs, ID_uses_rt,
        input  ID_EX_rs, ID_EX_rt, ID_EX_MemRead, ID_EX_WN, ID_EX_md,
        input  ex_branch_taken,
        input  EX_MEM_RegWrite, EX_MEM_WN, MEM_WB_RegWrite, MEM_WB_WN,
        input  dmem_wait,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
        output ex_mem_en, ex_mem_flush, mem_wb_en, fwd_a, fwd_b
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline hazard sequencer (load-use, branch, mult/div, dmem wait, forwarding)
// Optional HAZARD_STATS_EN adds stall/flush/freeze event counters.
module pipe_hazard_ctrl #(
    parameter int MD_CYCLES = 32,
    parameter int CNT_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    pipe_hazard_ctrl_if.slave   hz
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]         stall_count,
    output logic [31:0]         flush_count,
    output logic [31:0]         freeze_count
`endif
);

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_MD  = 1'b1
    } state_t;

    // A single-cycle mult/div needs no extra EX occupancy and just advances.
    localparam bit             MD_MULTI  = (MD_CYCLES > 1);
    localparam logic [CNT_W-1:0] MD_RELOAD = MD_MULTI ? CNT_W'(MD_CYCLES - 2) : '0;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;

    logic               pc_en;
    logic               if_id_en;
    logic               if_id_flush;
    logic               id_ex_en;
    logic               id_ex_flush;
    logic               ex_mem_en;
    logic               ex_mem_flush;
    logic               mem_wb_en;
    logic [1:0]         fwd_a;
    logic [1:0]         fwd_b;
    logic               stall_evt;

    logic               load_use;
    logic               rs_hit;
    logic               rt_hit;

    always_comb begin
        rs_hit   = hz.ID_uses_rs && (hz.ID_EX_WN == hz.ID_rs);
        rt_hit   = hz.ID_uses_rt && (hz.ID_EX_WN == hz.ID_rt);
        load_use = hz.ID_EX_MemRead && (hz.ID_EX_WN != 5'd0) && (rs_hit || rt_hit);
    end

    // EX/MEM result is younger than MEM/WB, so it wins when both match.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (!rst) begin
            if (hz.EX_MEM_RegWrite && (hz.EX_MEM_WN != 5'd0) && (hz.EX_MEM_WN == hz.ID_EX_rs))
                fwd_a = 2'b10;
            else if (hz.MEM_WB_RegWrite && (hz.MEM_WB_WN != 5'd0) && (hz.MEM_WB_WN == hz.ID_EX_rs))
                fwd_a = 2'b01;

            if (hz.EX_MEM_RegWrite && (hz.EX_MEM_WN != 5'd0) && (hz.EX_MEM_WN == hz.ID_EX_rt))
                fwd_b = 2'b10;
            else if (hz.MEM_WB_RegWrite && (hz.MEM_WB_WN != 5'd0) && (hz.MEM_WB_WN == hz.ID_EX_rt))
                fwd_b = 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_en    = 1'b1;
        ex_mem_flush = 1'b0;
        mem_wb_en    = 1'b1;
        stall_evt    = 1'b0;

        if (rst) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_en     = 1'b0;
            id_ex_flush  = 1'b1;
            ex_mem_en    = 1'b0;
            ex_mem_flush = 1'b1;
            mem_wb_en    = 1'b0;
            state_nxt    = ST_RUN;
            cnt_nxt      = '0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (hz.dmem_wait) begin
                        // Whole pipe holds; a taken branch in EX stays put and resolves after the wait.
                        pc_en     = 1'b0;
                        if_id_en  = 1'b0;
                        id_ex_en  = 1'b0;
                        ex_mem_en = 1'b0;
                        mem_wb_en = 1'b0;
                    end else if (hz.ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (hz.ID_EX_md && MD_MULTI) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_en     = 1'b0;
                        ex_mem_flush = 1'b1;
                        stall_evt    = 1'b1;
                        cnt_nxt      = MD_RELOAD;
                        state_nxt    = ST_MD;
                    end else if (load_use) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                        stall_evt   = 1'b1;
                    end
                end
                ST_MD: begin
                    if (hz.dmem_wait) begin
                        pc_en     = 1'b0;
                        if_id_en  = 1'b0;
                        id_ex_en  = 1'b0;
                        ex_mem_en = 1'b0;
                        mem_wb_en = 1'b0;
                    end else if (cnt != '0) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_en     = 1'b0;
                        ex_mem_flush = 1'b1;
                        stall_evt    = 1'b1;
                        cnt_nxt      = cnt - 1'b1;
                    end else begin
                        state_nxt = ST_RUN;
                    end
                end
                default: begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign hz.pc_en        = pc_en;
    assign hz.if_id_en     = if_id_en;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_en     = id_ex_en;
    assign hz.id_ex_flush  = id_ex_flush;
    assign hz.ex_mem_en    = ex_mem_en;
    assign hz.ex_mem_flush = ex_mem_flush;
    assign hz.mem_wb_en    = mem_wb_en;
    assign hz.fwd_a        = fwd_a;
    assign hz.fwd_b        = fwd_b;

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count  <= '0;
            flush_count  <= '0;
            freeze_count <= '0;
        end else begin
            if (stall_evt)
                stall_count <= stall_count + 32'd1;
            if (if_id_flush)
                flush_count <= flush_count + 32'd1;
            if (hz.dmem_wait)
                freeze_count <= freeze_count + 32'd1;
        end
    end
`else
    logic unused_stall;
    assign unused_stall = stall_evt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl with MD_CYCLES=4
module tb_pipe_hazard_ctrl;

    // Control vector order: pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush, mem_wb_en
    localparam logic [7:0] C_RST = 8'b0_0_1_0_1_0_1_0;
    localparam logic [7:0] C_ADV = 8'b1_1_0_1_0_1_0_1;
    localparam logic [7:0] C_FRZ = 8'b0_0_0_0_0_0_0_0;
    localparam logic [7:0] C_FLU = 8'b1_1_1_1_1_1_0_1;
    localparam logic [7:0] C_MDS = 8'b0_0_0_0_0_1_1_1;
    localparam logic [7:0] C_LU  = 8'b0_0_0_1_1_1_0_1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if hz ();

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count;
    logic [31:0] flush_count;
    logic [31:0] freeze_count;
`endif

    pipe_hazard_ctrl #(.MD_CYCLES(4), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .hz           (hz.slave)
`ifdef HAZARD_STATS_EN
        ,
        .stall_count  (stall_count),
        .flush_count  (flush_count),
        .freeze_count (freeze_count)
`endif
    );

    int checks = 0;
    int errors = 0;
    int pc_low_total = 0;

    logic [11:0] exp_q[$];
    string       tag_q[$];

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [7:0] ctl, input logic [3:0] fwd);
        exp_q.push_back({ctl, fwd});
        tag_q.push_back(tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hz.ID_rs           = 5'd0;
        hz.ID_rt           = 5'd0;
        hz.ID_uses_rs      = 1'b0;
        hz.ID_uses_rt      = 1'b0;
        hz.ID_EX_rs        = 5'd0;
        hz.ID_EX_rt        = 5'd0;
        hz.ID_EX_MemRead   = 1'b0;
        hz.ID_EX_WN        = 5'd0;
        hz.ID_EX_md        = 1'b0;
        hz.ex_branch_taken = 1'b0;
        hz.EX_MEM_RegWrite = 1'b0;
        hz.EX_MEM_WN       = 5'd0;
        hz.MEM_WB_RegWrite = 1'b0;
        hz.MEM_WB_WN       = 5'd0;
        hz.dmem_wait       = 1'b0;
    endtask

    always @(negedge clk) begin
        logic [7:0] ctl;
        ctl = {hz.pc_en, hz.if_id_en, hz.if_id_flush, hz.id_ex_en,
               hz.id_ex_flush, hz.ex_mem_en, hz.ex_mem_flush, hz.mem_wb_en};
        if (hz.pc_en === 1'b0)
            pc_low_total++;
        if (exp_q.size() != 0) begin
            logic [11:0] e;
            string       t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk(t, {ctl, hz.fwd_a, hz.fwd_b}, e);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pc_low_start;
        clear_inputs();

        // Reset, with forwarding inputs that would otherwise select EX/MEM
        tick();
        hz.EX_MEM_RegWrite = 1'b1; hz.EX_MEM_WN = 5'd5; hz.ID_EX_rs = 5'd5;
        expect_out("reset0", C_RST, 4'b0000);
        tick();
        expect_out("reset1", C_RST, 4'b0000);
        tick();
        rst = 1'b0;
        clear_inputs();
        expect_out("post_reset_adv", C_ADV, 4'b0000);

        // Load-use on rs, then the bubble leaves EX
        tick();
        hz.ID_EX_MemRead = 1'b1; hz.ID_EX_WN = 5'd8; hz.ID_rs = 5'd8; hz.ID_uses_rs = 1'b1;
        expect_out("lu_rs", C_LU, 4'b0000);
        tick();
        clear_inputs();
        expect_out("lu_after", C_ADV, 4'b0000);
        tick();
        hz.ID_EX_MemRead = 1'b1; hz.ID_EX_WN = 5'd8; hz.ID_rs = 5'd3; hz.ID_rt = 5'd8; hz.ID_uses_rt = 1'b1;
        expect_out("lu_rt", C_LU, 4'b0000);
        tick();
        hz.ID_uses_rt = 1'b0;
        expect_out("lu_rt_unused", C_ADV, 4'b0000);
        tick();
        hz.ID_EX_WN = 5'd0; hz.ID_rs = 5'd0; hz.ID_uses_rs = 1'b1;
        expect_out("lu_r0", C_ADV, 4'b0000);

        // Forwarding
        tick();
        clear_inputs();
        hz.EX_MEM_RegWrite = 1'b1; hz.EX_MEM_WN = 5'd5;
        hz.MEM_WB_RegWrite = 1'b1; hz.MEM_WB_WN = 5'd5; hz.ID_EX_rs = 5'd5;
        expect_out("fwd_both_a", C_ADV, 4'b1000);
        tick();
        hz.ID_EX_rt = 5'd5;
        expect_out("fwd_both_ab", C_ADV, 4'b1010);
        tick();
        hz.EX_MEM_WN = 5'd6;
        expect_out("fwd_memwb", C_ADV, 4'b0101);
        tick();
        hz.EX_MEM_WN = 5'd5; hz.EX_MEM_RegWrite = 1'b0; hz.ID_EX_rt = 5'd7;
        expect_out("fwd_wb_a_only", C_ADV, 4'b0100);
        tick();
        hz.EX_MEM_RegWrite = 1'b1; hz.EX_MEM_WN = 5'd0; hz.MEM_WB_WN = 5'd0; hz.ID_EX_rs = 5'd0;
        expect_out("fwd_r0", C_ADV, 4'b0000);

        // Mult/div, 4 cycles in EX: three stall cycles then completion
        tick();
        clear_inputs();
        pc_low_start = pc_low_total;
        hz.ID_EX_md = 1'b1;
        expect_out("md_start", C_MDS, 4'b0000);
        tick(); expect_out("md_c2", C_MDS, 4'b0000);
        tick(); hz.ex_branch_taken = 1'b1;
        expect_out("md_c1_branch_ignored", C_MDS, 4'b0000);
        tick(); hz.ex_branch_taken = 1'b0;
        expect_out("md_done", C_ADV, 4'b0000);
        tick(); hz.ID_EX_md = 1'b0;
        expect_out("md_next", C_ADV, 4'b0000);
        @(negedge clk); #1;
        chk("md_stall_cycles", 12'(pc_low_total - pc_low_start), 12'd3);

        // Mult/div with a two-cycle memory wait inside MD
        tick();
        pc_low_start = pc_low_total;
        hz.ID_EX_md = 1'b1;
        expect_out("mdw_start", C_MDS, 4'b0000);
        tick(); hz.dmem_wait = 1'b1; expect_out("mdw_frz0", C_FRZ, 4'b0000);
        tick(); expect_out("mdw_frz1", C_FRZ, 4'b0000);
        tick(); hz.dmem_wait = 1'b0; expect_out("mdw_c2", C_MDS, 4'b0000);
        tick(); expect_out("mdw_c1", C_MDS, 4'b0000);
        tick(); expect_out("mdw_done", C_ADV, 4'b0000);
        tick(); hz.ID_EX_md = 1'b0; expect_out("mdw_next", C_ADV, 4'b0000);
        @(negedge clk); #1;
        chk("mdw_stall_cycles", 12'(pc_low_total - pc_low_start), 12'd5);

        // Branch beats load-use in the same cycle
        tick();
        hz.ex_branch_taken = 1'b1;
        hz.ID_EX_MemRead = 1'b1; hz.ID_EX_WN = 5'd8; hz.ID_rs = 5'd8; hz.ID_uses_rs = 1'b1;
        expect_out("br_vs_lu", C_FLU, 4'b0000);
        tick();
        clear_inputs();
        expect_out("br_after", C_ADV, 4'b0000);

        // Branch held during a memory wait resolves once the wait drops
        tick();
        hz.ex_branch_taken = 1'b1; hz.dmem_wait = 1'b1;
        expect_out("br_wait0", C_FRZ, 4'b0000);
        tick(); expect_out("br_wait1", C_FRZ, 4'b0000);
        tick(); hz.dmem_wait = 1'b0; expect_out("br_released", C_FLU, 4'b0000);
        tick(); hz.ex_branch_taken = 1'b0; expect_out("br_done", C_ADV, 4'b0000);

        // Reset while in MD with cnt=2
        tick();
        hz.ID_EX_md = 1'b1;
        expect_out("rmd_start", C_MDS, 4'b0000);
        tick();
        rst = 1'b1;
        expect_out("rmd_reset", C_RST, 4'b0000);
        tick();
        rst = 1'b0;
        hz.ID_EX_md = 1'b0;
        expect_out("rmd_post_adv", C_ADV, 4'b0000);

        @(negedge clk); #1;
        chk("scoreboard_drained", 12'(exp_q.size()), 12'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
